// File: rtl/rr_interconnect.sv
// Round-robin interconnect: NUM_M handshake masters share one data path to NUM_S slaves.
// Grants are held for a burst ended by last or the beat limit; unmapped targets are sunk with m_err.
module rr_interconnect #(
  parameter int unsigned NUM_M     = 2,
  parameter int unsigned NUM_S     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_M-1:0]           m_valid,
  output logic [NUM_M-1:0]           m_ready,
  input  logic [NUM_M*DATA_W-1:0]    m_data,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr,
  input  logic [NUM_M-1:0]           m_last,
  output logic [NUM_M-1:0]           m_err,
  output logic [NUM_S-1:0]           s_valid,
  input  logic [NUM_S-1:0]           s_ready,
  output logic [DATA_W-1:0]          s_data,
  output logic                       s_last,
  output logic [NUM_M-1:0]           grant,
  output logic [$clog2(NUM_M)-1:0]   grant_id
);

  localparam int unsigned ID_W  = $clog2(NUM_M);
  localparam int unsigned SEL_W = (NUM_S > 2) ? $clog2(NUM_S) : 1;
  localparam int unsigned CNT_W = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [SEL_W:0]   NUM_S_W  = (SEL_W + 1)'(NUM_S);
  localparam logic [ID_W-1:0]  LAST_M   = ID_W'(NUM_M - 1);

  typedef enum logic [1:0] {IDLE, XFER, ERR} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic [SEL_W-1:0]   tgt, tgt_nxt;
  logic [NUM_M-1:0]   grant_nxt;
  logic [ID_W-1:0]    gid_nxt;

  logic [DATA_W-1:0]  data_a [NUM_M];
  logic [SEL_W-1:0]   tgt_a  [NUM_M];
  logic               addr_unused;

  logic               found;
  logic [ID_W-1:0]    sel, idx;
  logic [SEL_W-1:0]   sel_tgt;
  logic               g_valid, g_last, lim, beat;

  // Unpack per-master buses; only the slave-select field of each address is decoded
  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
    assign data_a[gi] = m_data[gi*DATA_W +: DATA_W];
    assign tgt_a[gi]  = m_addr[gi*ADDR_W + ADDR_W - 1 -: SEL_W];
  end
  assign addr_unused = ^m_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      beat_cnt <= '0;
      tgt      <= '0;
      grant    <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
      tgt      <= tgt_nxt;
      grant    <= grant_nxt;
      grant_id <= gid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = beat_cnt;
    tgt_nxt   = tgt;
    grant_nxt = grant;
    gid_nxt   = grant_id;
    m_ready   = '0;
    m_err     = '0;
    s_valid   = '0;
    s_data    = '0;
    s_last    = 1'b0;
    found     = 1'b0;
    sel       = '0;
    idx       = '0;
    beat      = 1'b0;

    // First requester at or after ptr, circularly
    for (int unsigned i = 0; i < NUM_M; i++) begin
      idx = ID_W'((32'(ptr) + i) % NUM_M);
      if (!found && m_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    sel_tgt = tgt_a[sel];

    g_valid = m_valid[grant_id];
    g_last  = m_last[grant_id];
    lim     = (beat_cnt == LAST_CNT);

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = NUM_M'(1) << sel;
          gid_nxt   = sel;
          tgt_nxt   = sel_tgt;
          cnt_nxt   = '0;
          ptr_nxt   = (sel == LAST_M) ? '0 : sel + ID_W'(1);
          state_nxt = ({1'b0, sel_tgt} < NUM_S_W) ? XFER : ERR;
        end
      end
      XFER: begin
        s_valid[tgt]      = g_valid;
        m_ready[grant_id] = s_ready[tgt];
        s_data            = data_a[grant_id];
        s_last            = g_last | lim;
        beat              = g_valid & s_ready[tgt];
      end
      ERR: begin
        m_ready[grant_id] = g_valid;
        m_err[grant_id]   = g_valid;
        beat              = g_valid;
      end
      default: state_nxt = IDLE;
    endcase

    // Burst ends on last or on the beat limit; the IDLE bubble follows
    if (beat) begin
      if (g_last || lim) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        grant_nxt = '0;
        gid_nxt   = '0;
      end else begin
        cnt_nxt = beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_interconnect.sv
// Directed bench for rr_interconnect: a 2x2 instance with a 4-beat limit and a
// 2x3 instance that exercises the decode-error path; both share the master inputs.
module tb_rr_interconnect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_valid, m_last, s_ready;
  logic [15:0] m_data, m_addr;
  logic [1:0]  m_ready, m_err, s_valid, grant;
  logic [7:0]  s_data;
  logic        s_last;
  logic [0:0]  grant_id;

  logic [2:0]  e_s_ready, e_s_valid;
  logic [1:0]  e_m_ready, e_m_err, e_grant;
  logic [7:0]  e_s_data;
  logic        e_s_last;
  logic [0:0]  e_grant_id;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] single_d [3] = '{8'hAA, 8'hBB, 8'hCC};
  logic [1:0] fair_g   [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic [1:0] lim_g    [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
  logic       lim_l    [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] exp_d;

  rr_interconnect #(.NUM_M(2), .NUM_S(2), .DATA_W(8), .ADDR_W(8), .MAX_BURST(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last), .m_err(m_err), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .grant(grant), .grant_id(grant_id)
  );

  rr_interconnect #(.NUM_M(2), .NUM_S(3), .DATA_W(8), .ADDR_W(8), .MAX_BURST(16)) u_err (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_ready(e_m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last), .m_err(e_m_err), .s_valid(e_s_valid), .s_ready(e_s_ready),
    .s_data(e_s_data), .s_last(e_s_last), .grant(e_grant), .grant_id(e_grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; m_valid = '0; m_last = '0; m_data = '0; m_addr = '0;
    s_ready = '0; e_s_ready = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; m_valid = 2'b11; m_last = '0; m_data = 16'h2211; m_addr = 16'h8000;
    s_ready = 2'b11; e_s_ready = 3'b111;
    tick;
    @(negedge clk);
    vectors++; if ({grant, grant_id, m_ready, m_err, s_valid} !== 9'd0) begin miscompares++;
      $display("FAIL reset_ctl: got %b want 0", {grant, grant_id, m_ready, m_err, s_valid}); end
    vectors++; if ({s_data, s_last} !== 9'd0) begin miscompares++;
      $display("FAIL reset_data: got %h want 0", {s_data, s_last}); end
    vectors++; if ({e_grant, e_m_ready, e_m_err, e_s_valid, e_s_data} !== 17'd0) begin miscompares++;
      $display("FAIL reset_err_inst: got %h want 0", {e_grant, e_m_ready, e_m_err, e_s_valid, e_s_data}); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    s_ready = 2'b11; m_addr = 16'h8000; m_data = 16'h0010; m_valid = 2'b01;
    tick; tick; tick;
    @(negedge clk);
    vectors++; if ({grant, s_valid} !== 4'b0101) begin miscompares++;
      $display("FAIL midrst_pre: got %b want 0101", {grant, s_valid}); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({grant, m_ready, s_valid, s_data, s_last} !== 15'd0) begin miscompares++;
      $display("FAIL midrst_outs: got %h want 0", {grant, m_ready, s_valid, s_data, s_last}); end
    m_valid = 2'b11;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++;
      $display("FAIL midrst_idle: got %b want 00", grant); end
    tick;
    @(negedge clk);
    vectors++; if ({grant, grant_id} !== 3'b010) begin miscompares++;
      $display("FAIL midrst_regrant: got %b want 010", {grant, grant_id}); end
  endtask

  task automatic test_single;
    do_reset;
    s_ready = 2'b11; m_addr = 16'h0000; m_valid = 2'b01; m_data = {8'h00, single_d[0]};
    @(negedge clk);
    vectors++; if ({grant, s_valid} !== 4'b0000) begin miscompares++;
      $display("FAIL single_idle: got %b want 0000", {grant, s_valid}); end
    tick;
    for (int k = 0; k < 3; k++) begin
      m_data[7:0] = single_d[k];
      m_last = (k == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      vectors++; if ({grant, m_ready, s_valid} !== 6'b010101) begin miscompares++;
        $display("FAIL single_hs[%0d]: got %b want 010101", k, {grant, m_ready, s_valid}); end
      vectors++; if ({s_data, s_last} !== {single_d[k], (k == 2)}) begin miscompares++;
        $display("FAIL single_data[%0d]: got %h/%b want %h/%b", k, s_data, s_last, single_d[k], (k == 2)); end
      tick;
    end
    m_valid = 2'b00; m_last = 2'b00;
    @(negedge clk);
    vectors++; if ({grant, s_valid} !== 4'b0000) begin miscompares++;
      $display("FAIL single_end: got %b want 0000", {grant, s_valid}); end
  endtask

  task automatic test_fairness;
    do_reset;
    s_ready = 2'b11; m_addr = 16'h8000; m_data = 16'h2211; m_last = 2'b11; m_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      exp_d = (fair_g[k] == 2'b01) ? 8'h11 : (fair_g[k] == 2'b10) ? 8'h22 : 8'h00;
      @(negedge clk);
      vectors++; if ({grant, grant_id} !== {fair_g[k], fair_g[k][1]}) begin miscompares++;
        $display("FAIL fair_grant[%0d]: got %b want %b", k, {grant, grant_id}, {fair_g[k], fair_g[k][1]}); end
      vectors++; if ({s_valid, m_ready, s_data} !== {fair_g[k], fair_g[k], exp_d}) begin miscompares++;
        $display("FAIL fair_path[%0d]: got %b/%b/%h want %b/%b/%h", k, s_valid, m_ready, s_data,
                 fair_g[k], fair_g[k], exp_d); end
      tick;
    end
  endtask

  task automatic test_backpressure;
    do_reset;
    s_ready = 2'b01; m_addr = 16'h8000; m_data = 16'h5A11; m_last = 2'b00; m_valid = 2'b10;
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++;
      $display("FAIL bp_idle: got %b want 00", grant); end
    tick;
    m_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if ({grant, m_ready, s_valid, s_data} !== {2'b10, 2'b00, 2'b10, 8'h5A}) begin miscompares++;
        $display("FAIL bp_stall[%0d]: got %b/%b/%b/%h want 10/00/10/5a", k, grant, m_ready, s_valid, s_data); end
      tick;
    end
    s_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      m_data[15:8] = 8'h5A + 8'(k);
      @(negedge clk);
      vectors++; if ({m_ready, s_valid, s_data, s_last} !== {2'b10, 2'b10, 8'h5A + 8'(k), (k == 3)}) begin
        miscompares++;
        $display("FAIL bp_beat[%0d]: got %b/%b/%h/%b want 10/10/%h/%b", k, m_ready, s_valid, s_data, s_last,
                 8'h5A + 8'(k), (k == 3)); end
      tick;
    end
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++;
      $display("FAIL bp_bubble: got %b want 00", grant); end
    tick;
    @(negedge clk);
    vectors++; if ({grant, s_valid} !== 4'b0101) begin miscompares++;
      $display("FAIL bp_next: got %b want 0101", {grant, s_valid}); end
  endtask

  task automatic test_beat_limit;
    do_reset;
    s_ready = 2'b11; m_addr = 16'h8000; m_last = 2'b00; m_valid = 2'b01; m_data = 16'h0001;
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++;
      $display("FAIL lim_idle: got %b want 00", grant); end
    tick;
    for (int k = 0; k < 4; k++) begin
      m_data[7:0] = 8'(k + 1);
      @(negedge clk);
      vectors++; if ({grant, s_data, s_last} !== {2'b01, 8'(k + 1), (k == 3)}) begin miscompares++;
        $display("FAIL lim_beat[%0d]: got %b/%h/%b want 01/%h/%b", k, grant, s_data, s_last, 8'(k + 1), (k == 3)); end
      tick;
    end
    m_data[7:0] = 8'h05;
    @(negedge clk);
    vectors++; if ({grant, s_valid, m_ready} !== 6'd0) begin miscompares++;
      $display("FAIL lim_bubble: got %b want 0", {grant, s_valid, m_ready}); end
    tick;
    for (int k = 0; k < 2; k++) begin
      m_data[7:0] = 8'(k + 5);
      @(negedge clk);
      vectors++; if ({grant, s_data, s_last} !== {2'b01, 8'(k + 5), 1'b0}) begin miscompares++;
        $display("FAIL lim_rest[%0d]: got %b/%h/%b want 01/%h/0", k, grant, s_data, s_last, 8'(k + 5)); end
      tick;
    end
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if ({grant, s_valid} !== 4'b0100) begin miscompares++;
      $display("FAIL lim_hold: got %b want 0100", {grant, s_valid}); end

    do_reset;
    s_ready = 2'b11; m_addr = 16'h8000; m_last = 2'b10; m_data = 16'h9901; m_valid = 2'b11;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vectors++; if ({grant, s_last} !== {lim_g[k], lim_l[k]}) begin miscompares++;
        $display("FAIL lim_rearb[%0d]: got %b/%b want %b/%b", k, grant, s_last, lim_g[k], lim_l[k]); end
      tick;
    end
  endtask

  task automatic test_decode_err;
    do_reset;
    e_s_ready = 3'b111; m_addr = 16'h80C0; m_data = 16'h3C77; m_last = 2'b00; m_valid = 2'b01;
    @(negedge clk);
    vectors++; if (e_grant !== 2'b00) begin miscompares++;
      $display("FAIL err_idle: got %b want 00", e_grant); end
    tick;
    @(negedge clk);
    vectors++; if ({e_grant, e_m_ready, e_m_err, e_s_valid, e_s_data} !== {2'b01, 2'b01, 2'b01, 3'b000, 8'h00}) begin
      miscompares++;
      $display("FAIL err_beat1: got %b/%b/%b/%b/%h want 01/01/01/000/00", e_grant, e_m_ready, e_m_err,
               e_s_valid, e_s_data); end
    tick;
    m_valid = 2'b00;
    @(negedge clk);
    vectors++; if ({e_grant, e_m_ready, e_m_err} !== 6'b010000) begin miscompares++;
      $display("FAIL err_wait: got %b want 010000", {e_grant, e_m_ready, e_m_err}); end
    tick;
    m_valid = 2'b01; m_last = 2'b01;
    @(negedge clk);
    vectors++; if ({e_m_ready, e_m_err, e_s_valid} !== 7'b0101000) begin miscompares++;
      $display("FAIL err_last: got %b want 0101000", {e_m_ready, e_m_err, e_s_valid}); end
    tick;
    m_valid = 2'b10; m_last = 2'b10;
    @(negedge clk);
    vectors++; if (e_grant !== 2'b00) begin miscompares++;
      $display("FAIL err_end: got %b want 00", e_grant); end
    tick;
    @(negedge clk);
    vectors++; if ({e_grant, e_s_valid, e_m_err, e_s_data} !== {2'b10, 3'b100, 2'b00, 8'h3C}) begin miscompares++;
      $display("FAIL err_slave2: got %b/%b/%b/%h want 10/100/00/3c", e_grant, e_s_valid, e_m_err, e_s_data); end
    tick;
    m_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_reset_mid_burst;
    test_single;
    test_fairness;
    test_backpressure;
    test_beat_limit;
    test_decode_err;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
